// File: rtl/mem_pkg.sv
// Shared constants and lane addressing helper for the MEM-stage data memory.
package mem_pkg;

  localparam int DATA_W              = 64;
  localparam int BYTES_PER_WORD      = 8;
  localparam int DEFAULT_DEPTH_BYTES = 1024;

  // Byte index of lane k; depth is a power of two, so masking is the modulo.
  function automatic logic [63:0] lane_index(input logic [63:0] addr,
                                             input int unsigned k,
                                             input int unsigned depth);
    return (addr + 64'(k)) & (64'(depth) - 64'd1);
  endfunction

endpackage

// File: rtl/data_memory.sv
// Byte-addressable little-endian 64-bit data memory: synchronous stores,
// combinational loads, unaligned and wrap-around accesses, async clear.
module data_memory
  import mem_pkg::*;
#(
  parameter int DEPTH_BYTES = DEFAULT_DEPTH_BYTES,
  parameter int ADDR_W      = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] address,
  input  logic [63:0]       write_data,
  output logic [63:0]       read_data
);

  localparam int AW = $clog2(DEPTH_BYTES);

  logic [7:0]        r_mem [DEPTH_BYTES];
  logic [AW-1:0]     w_addr_low;
  logic [AW-1:0]     w_idx [BYTES_PER_WORD];
  logic [DATA_W-1:0] w_rdata;

  assign w_addr_low = address[AW-1:0];

  // Address bits above the array size only alias; they never select storage.
  generate
    if (ADDR_W > AW) begin : g_upper
      logic w_addr_unused;
      assign w_addr_unused = ^address[ADDR_W-1:AW];
    end
  endgenerate

  generate
    for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_lane
      logic [63:0] w_idx_full;
      assign w_idx_full = lane_index({{(64-AW){1'b0}}, w_addr_low}, gi, DEPTH_BYTES);
      assign w_idx[gi]  = w_idx_full[AW-1:0];
      assign w_rdata[8*gi +: 8] = r_mem[w_idx[gi]];
    end
  endgenerate

  // DEPTH_BYTES >= 8 guarantees the eight lane indices never collide.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j < DEPTH_BYTES; j++) begin
        r_mem[j] <= 8'h00;
      end
    end else if (MemWrite) begin
      for (int k = 0; k < BYTES_PER_WORD; k++) begin
        r_mem[w_idx[k]] <= write_data[8*k +: 8];
      end
    end
  end

  assign read_data = MemRead ? w_rdata : 64'h0;

endmodule

// File: tb/tb_data_memory.sv
// Directed vector bench for data_memory: table of single-cycle accesses plus
// hand-written reset and edge-sampling sequences.
module tb_data_memory;

  localparam int DEPTH = 1024;

  logic        clk;
  logic        rst_n;
  logic        MemRead;
  logic        MemWrite;
  logic [63:0] address;
  logic [63:0] write_data;
  logic [63:0] read_data;

  int n_vec;
  int n_err;

  typedef struct {
    logic        rd;
    logic        wr;
    logic [63:0] addr;
    logic [63:0] wd;
    logic [63:0] exp;
  } vec_t;

  vec_t vecs [14];

  data_memory #(.DEPTH_BYTES(DEPTH), .ADDR_W(64)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .MemRead(MemRead),
    .MemWrite(MemWrite),
    .address(address),
    .write_data(write_data),
    .read_data(read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(logic rd, logic wr, logic [63:0] a, logic [63:0] wd, logic [63:0] e);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = a; v.wd = wd; v.exp = e;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] exp);
    n_vec++;
    if (read_data !== exp) begin
      n_err++;
      $display("FAIL %s: read_data=%h expected %h", name, read_data, exp);
    end else begin
      $display("ok   %s: addr=%0d read_data=%h", name, address[9:0], read_data);
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;

    vecs[0]  = mk(1, 0, 64'd3,    64'h0,                 64'h0);
    vecs[1]  = mk(0, 1, 64'd3,    64'hDEADBEEFCAFEBABE,  64'h0);
    vecs[2]  = mk(1, 0, 64'd3,    64'h0,                 64'hDEADBEEFCAFEBABE);
    vecs[3]  = mk(1, 0, 64'd8,    64'h0,                 64'h0000000000DEADBE);
    vecs[4]  = mk(1, 0, 64'd0,    64'h0,                 64'hEFCAFEBABE000000);
    vecs[5]  = mk(0, 0, 64'd5,    64'h0,                 64'h0);
    vecs[6]  = mk(1, 1, 64'd1022, 64'h0123456789ABCDEF,  64'hFEBABE0000000000);
    vecs[7]  = mk(1, 0, 64'd1022, 64'h0,                 64'h0123456789ABCDEF);
    vecs[8]  = mk(1, 0, 64'd0,    64'h0,                 64'hEFCA0123456789AB);
    vecs[9]  = mk(1, 0, 64'd1020, 64'h0,                 64'h456789ABCDEF0000);
    vecs[10] = mk(1, 0, 64'h1000_0000_0000_0003, 64'h0,  64'hDEADBEEFCA012345);
    vecs[11] = mk(0, 1, 64'hFFFF_0000_0000_0010, 64'h1122334455667788, 64'h0);
    vecs[12] = mk(1, 0, 64'd16,   64'h0,                 64'h1122334455667788);
    vecs[13] = mk(1, 0, 64'd15,   64'h0,                 64'h2233445566778800);

    rst_n = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; address = '0; write_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Each vector is driven on the falling edge and checked before the next
    // rising edge, which then commits any store it requested.
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      MemRead = vecs[i].rd; MemWrite = vecs[i].wr;
      address = vecs[i].addr; write_data = vecs[i].wd;
      #1;
      check($sformatf("vec%0d", i), vecs[i].exp);
    end
    @(negedge clk);
    MemWrite = 1'b0;

    // Store request that rises and falls between edges must leave no trace.
    @(posedge clk); #1;
    MemRead = 1'b1; MemWrite = 1'b1; address = 64'd50; write_data = 64'hA5A5A5A5A5A5A5A5;
    #2 MemWrite = 1'b0;
    @(posedge clk); #1;
    check("glitch_store", 64'h0);

    // Asynchronous reset between edges clears immediately.
    address = 64'd3; #1;
    check("pre_reset", 64'hDEADBEEFCA012345);
    rst_n = 1'b0; #1;
    check("async_reset_a3", 64'h0);
    address = 64'd16; #1;
    check("async_reset_a16", 64'h0);

    // Store attempted while held in reset is dropped.
    @(negedge clk);
    MemWrite = 1'b1; address = 64'd3; write_data = 64'h5555AAAA5555AAAA;
    @(posedge clk); #1;
    check("store_in_reset", 64'h0);
    @(negedge clk);
    MemWrite = 1'b0;
    #2 rst_n = 1'b1; #1;
    check("after_release", 64'h0);

    // First store is taken on the first rising edge after release.
    MemWrite = 1'b1; address = 64'd40; write_data = 64'hCAFEF00D12345678;
    @(posedge clk); #1;
    MemWrite = 1'b0; #1;
    check("first_store", 64'hCAFEF00D12345678);
    MemRead = 1'b0; #1;
    check("read_gated", 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: read_data=%h expected completion", read_data);
    $fatal(1, "timeout");
  end

endmodule
